// File: rtl/alu_pipe.sv
// Two-stage pipelined integer ALU with valid/ready handshake, registered flags and sticky overflow.
// Optional build macro ALU_PIPE_SIGNED_CMP_EN makes greater/is_eq/less compare as two's complement.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             oe,
  input  logic             clr_sticky,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             parity,
  output logic             overflow,
  output logic             greater,
  output logic             is_eq,
  output logic             less,
  output logic             ovf_sticky
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  logic             s1_valid;
  logic             s2_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;
  logic             s1_oe;
  logic             adv1;
  logic             adv2;

  logic [WIDTH-1:0] res;
  logic             ovf_c;
  logic             gt_c;
  logic             eq_c;
  logic             lt_c;

  // A stage may load when it is empty or its contents move on this edge.
  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  always_comb begin
    res   = '0;
    ovf_c = 1'b0;
    case (s1_op)
      OP_ADD: begin
        res   = s1_a + s1_b;
        ovf_c = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (res[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_SUB: begin
        res   = s1_a - s1_b;
        ovf_c = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (res[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_AND:  res = s1_a & s1_b;
      OP_OR:   res = s1_a | s1_b;
      OP_XOR:  res = s1_a ^ s1_b;
      OP_SHL:  res = s1_a << s1_b[SHW-1:0];
      OP_SHR:  res = s1_a >> s1_b[SHW-1:0];
      default: res = s1_a;
    endcase
  end

`ifdef ALU_PIPE_SIGNED_CMP_EN
  assign gt_c = $signed(s1_a) > $signed(s1_b);
  assign lt_c = $signed(s1_a) < $signed(s1_b);
`else
  assign gt_c = s1_a > s1_b;
  assign lt_c = s1_a < s1_b;
`endif
  assign eq_c = s1_a == s1_b;

  // Operand stage; bubbles clear the valid bit but leave the operand registers alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
      s1_oe    <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= a;
        s1_b  <= b;
        s1_op <= op_e'(op);
        s1_oe <= oe;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      y        <= '0;
      parity   <= 1'b0;
      overflow <= 1'b0;
      greater  <= 1'b0;
      is_eq    <= 1'b0;
      less     <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        y        <= s1_oe ? res : '0;
        parity   <= ^res;
        overflow <= ovf_c;
        greater  <= gt_c;
        is_eq    <= eq_c;
        less     <= lt_c;
      end
    end
  end

  // Setting on a delivered overflow beats a simultaneous clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (s2_valid && out_ready && overflow) begin
      ovf_sticky <= 1'b1;
    end else if (clr_sticky) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe: directed vector table, handshake/sticky/reset sequences and
// randomized traffic scored against an arithmetic reference model.
module tb_alu_pipe;

  localparam int W    = 8;
  localparam int MAXS = 2 ** (W - 1) - 1;
  localparam int MINS = -(2 ** (W - 1));
`ifdef ALU_PIPE_SIGNED_CMP_EN
  localparam bit SIGNED = 1'b1;
`else
  localparam bit SIGNED = 1'b0;
`endif
  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         oe;
    logic [W-1:0] y;
    logic         par;
    logic         ovf;
    logic [2:0]   cmp;
  } vec_t;

  typedef struct {
    logic [W-1:0] y;
    logic         par;
    logic         ovf;
    logic [2:0]   cmp;
  } result_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         oe;
  logic         clr_sticky;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         parity;
  logic         overflow;
  logic         greater;
  logic         is_eq;
  logic         less;
  logic         ovf_sticky;

  int      nChecks = 0;
  int      nFails  = 0;
  int      popCount = 0;
  bit      scbOn = 1'b0;
  bit      accLast = 1'b0;
  bit      stickyModel = 1'b0;
  bit      gotOvf;
  result_t monExp;
  result_t expQ[$];
  vec_t    vecs[12];

  alu_pipe #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .op         (op),
    .oe         (oe),
    .clr_sticky (clr_sticky),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y          (y),
    .parity     (parity),
    .overflow   (overflow),
    .greater    (greater),
    .is_eq      (is_eq),
    .less       (less),
    .ovf_sticky (ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from plain integer arithmetic on the operand values.
  function automatic result_t refModel(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                       input logic [2:0] opi, input logic oei);
    result_t      r;
    int           ua, ub, sa, sb, full, amt;
    logic [W-1:0] res;
    ua = int'(ai);
    ub = int'(bi);
    sa = int'($signed(ai));
    sb = int'($signed(bi));
    amt = ub % W;
    r.ovf = 1'b0;
    case (opi)
      3'd0: begin full = ua + ub; r.ovf = (sa + sb > MAXS) || (sa + sb < MINS); end
      3'd1: begin full = ua - ub; r.ovf = (sa - sb > MAXS) || (sa - sb < MINS); end
      3'd2: full = ua & ub;
      3'd3: full = ua | ub;
      3'd4: full = ua ^ ub;
      3'd5: full = ua * (1 << amt);
      3'd6: full = ua / (1 << amt);
      default: full = ua;
    endcase
    res   = full[W-1:0];
    r.par = 1'($countones(res) % 2);
    r.y   = oei ? res : '0;
    if (SIGNED) r.cmp = (sa > sb) ? CMP_GT : (sa == sb) ? CMP_EQ : CMP_LT;
    else        r.cmp = (ua > ub) ? CMP_GT : (ua == ub) ? CMP_EQ : CMP_LT;
    return r;
  endfunction

  // Scoreboard: predicts sticky, checks delivered beats in order, records accepted beats.
  always @(negedge clk) begin
    if (scbOn) begin
      checkOutput("scb_sticky", ovf_sticky, stickyModel);
      gotOvf = 1'b0;
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("scb_unexpected_beat", 1, 0);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("scb_y", y, monExp.y);
          checkOutput("scb_parity", parity, monExp.par);
          checkOutput("scb_overflow", overflow, monExp.ovf);
          checkOutput("scb_cmp", {greater, is_eq, less}, monExp.cmp);
          gotOvf = monExp.ovf;
          popCount++;
        end
      end
      stickyModel = gotOvf ? 1'b1 : (clr_sticky ? 1'b0 : stickyModel);
      if (in_valid && in_ready) expQ.push_back(refModel(a, b, op, oe));
      accLast = in_valid && in_ready;
    end
  end

  task automatic driveBeat(input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic [2:0] opv, input logic oev);
    a = av; b = bv; op = opv; oe = oev; in_valid = 1'b1;
  endtask

  // One beat into an idle pipe; returns just after the accepting edge.
  task automatic applyStimulus(input vec_t v);
    @(posedge clk); #1;
    driveBeat(v.a, v.b, v.op, v.oe);
    @(negedge clk);
    checkOutput("tbl_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic doReset();
    scbOn = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    expQ.delete();
    stickyModel = 1'b0;
  endtask

  initial begin
    logic [W-1:0] heldY;
    bit           tblSticky;
    int           n0;

    vecs[0]  = '{8'h7F, 8'h01, 3'd0, 1'b1, 8'h80, 1'b1, 1'b1, CMP_GT};
    vecs[1]  = '{8'h05, 8'h05, 3'd1, 1'b1, 8'h00, 1'b0, 1'b0, CMP_EQ};
    vecs[2]  = '{8'h81, 8'h09, 3'd5, 1'b1, 8'h02, 1'b1, 1'b0, SIGNED ? CMP_LT : CMP_GT};
    vecs[3]  = '{8'h81, 8'h07, 3'd6, 1'b1, 8'h01, 1'b1, 1'b0, SIGNED ? CMP_LT : CMP_GT};
    vecs[4]  = '{8'hF0, 8'h0F, 3'd4, 1'b0, 8'h00, 1'b0, 1'b0, SIGNED ? CMP_LT : CMP_GT};
    vecs[5]  = '{8'h80, 8'h01, 3'd7, 1'b1, 8'h80, 1'b1, 1'b0, SIGNED ? CMP_LT : CMP_GT};
    vecs[6]  = '{8'h80, 8'h01, 3'd1, 1'b1, 8'h7F, 1'b1, 1'b1, SIGNED ? CMP_LT : CMP_GT};
    vecs[7]  = '{8'hF0, 8'h3C, 3'd2, 1'b1, 8'h30, 1'b0, 1'b0, SIGNED ? CMP_LT : CMP_GT};
    vecs[8]  = '{8'h0A, 8'h05, 3'd3, 1'b1, 8'h0F, 1'b0, 1'b0, CMP_GT};
    vecs[9]  = '{8'hFF, 8'h01, 3'd0, 1'b1, 8'h00, 1'b0, 1'b0, SIGNED ? CMP_LT : CMP_GT};
    vecs[10] = '{8'h01, 8'h02, 3'd1, 1'b1, 8'hFF, 1'b0, 1'b0, CMP_LT};
    vecs[11] = '{8'h01, 8'h07, 3'd5, 1'b1, 8'h80, 1'b1, 1'b0, CMP_LT};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    a = '0; b = '0; op = '0; oe = 1'b0;
    #3;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_y", y, 0);
    checkOutput("rst_flags", {parity, overflow, greater, is_eq, less}, 0);
    checkOutput("rst_sticky", ovf_sticky, 0);
    #9 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1);

    $display("[TB] directed vector table");
    tblSticky = 1'b0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      @(negedge clk);
      checkOutput("tbl_out_valid", out_valid, 1);
      checkOutput("tbl_y", y, vecs[i].y);
      checkOutput("tbl_parity", parity, vecs[i].par);
      checkOutput("tbl_overflow", overflow, vecs[i].ovf);
      checkOutput("tbl_cmp", {greater, is_eq, less}, vecs[i].cmp);
      tblSticky = tblSticky | vecs[i].ovf;
      @(posedge clk);
      @(negedge clk);
      checkOutput("tbl_sticky", ovf_sticky, tblSticky);
      checkOutput("tbl_bubble", out_valid, 0);
    end

    $display("[TB] sticky clear and set-wins");
    @(posedge clk); #1 clr_sticky = 1'b1;
    @(posedge clk); #1 clr_sticky = 1'b0;
    @(negedge clk);
    checkOutput("sticky_clear", ovf_sticky, 0);
    applyStimulus(vecs[0]);
    @(posedge clk); #1 clr_sticky = 1'b1;
    @(negedge clk);
    checkOutput("sticky_race_valid", out_valid, 1);
    @(posedge clk); #1 clr_sticky = 1'b0;
    @(negedge clk);
    checkOutput("sticky_set_wins", ovf_sticky, 1);
    @(posedge clk); #1 clr_sticky = 1'b1;
    @(posedge clk); #1 clr_sticky = 1'b0;
    @(negedge clk);
    checkOutput("sticky_clear2", ovf_sticky, 0);

    $display("[TB] backpressure");
    doReset();
    scbOn = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    driveBeat(8'h7F, 8'h01, 3'd0, 1'b1);
    @(posedge clk); #1 driveBeat(8'h10, 8'h03, 3'd1, 1'b1);
    @(posedge clk); #1 driveBeat(8'hAA, 8'h0F, 3'd4, 1'b1);
    @(negedge clk);
    checkOutput("bp_in_ready_low", in_ready, 0);
    checkOutput("bp_out_valid", out_valid, 1);
    checkOutput("bp_first_y", y, 8'h80);
    heldY = y;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("bp_y_stable", y, heldY);
    checkOutput("bp_ovf_stable", overflow, 1);
    checkOutput("bp_still_full", in_ready, 0);
    @(posedge clk); #1 out_ready = 1'b1;
    n0 = popCount;
    @(negedge clk);
    checkOutput("bp_in_ready_high", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_drain2", out_valid, 1);
    @(negedge clk);
    checkOutput("bp_drain3", out_valid, 1);
    @(negedge clk);
    checkOutput("bp_drained", out_valid, 0);
    checkOutput("bp_delivered", popCount - n0, 3);

    $display("[TB] reset mid-stream");
    @(posedge clk); #1 out_ready = 1'b0;
    driveBeat(8'h40, 8'h40, 3'd0, 1'b1);
    @(posedge clk); #1 driveBeat(8'h12, 8'h34, 3'd3, 1'b1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid_sticky_before", ovf_sticky, 1);
    scbOn = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_out_valid", out_valid, 0);
    checkOutput("mid_sticky", ovf_sticky, 0);
    checkOutput("mid_y", y, 0);
    expQ.delete();
    stickyModel = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("mid_no_stale", out_valid, 0);
    end

    $display("[TB] randomized traffic");
    doReset();
    scbOn = 1'b1;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      if (!in_valid || accLast) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a  = W'($urandom);
        b  = W'($urandom);
        op = 3'($urandom);
        oe = ($urandom_range(0, 4) != 0);
      end
      out_ready  = ($urandom_range(0, 3) != 0);
      clr_sticky = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("rand_drain_empty", expQ.size(), 0);
    checkOutput("rand_out_idle", out_valid, 0);
    scbOn = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined integer ALU; successor to the team's 8-bit combinational ALU.
- Adds configurable width, 3-bit opcode (shifts, XOR, pass), and valid/ready handshake on both sides with full backpressure.
- Adds registered flags and a sticky overflow register.
- Sits between operand-issue logic and the writeback/flag consumer in the datapath.

Parameters:
- WIDTH, 8, operand/result width; power of two, >= 4.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; low SHW bits are the shift amount for shift ops.
- op  input  3  opcode.
- oe  input  1  result output enable, captured with the beat.
- clr_sticky  input  1  clears ovf_sticky.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result beat.
- y  output  WIDTH  result; all zeros when the captured oe=0.
- parity  output  1  XOR of all bits of the unmasked result.
- overflow  output  1  signed overflow for ADD/SUB; 0 for all other ops.
- greater  output  1  a > b.
- is_eq  output  1  a == b.
- less  output  1  a < b.
- ovf_sticky  output  1  set by any delivered beat with overflow=1.

Behaviour:
- Reset: every output register, both stage valid bits and ovf_sticky clear to 0 asynchronously. in_ready=1 once reset is released.
- Opcodes:
  - 000 ADD: a+b, modulo 2^WIDTH.
  - 001 SUB: a-b, modulo 2^WIDTH.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SHL: a << b[SHW-1:0], zero fill.
  - 110 SHR: logical a >> b[SHW-1:0].
  - 111 PASS: a.
- Overflow: ADD when a and b have the same MSB and the result MSB differs; SUB when a and b have different MSBs and the result MSB differs from a's MSB.
- Compare flags are computed for every op; exactly one of greater/is_eq/less is 1. Comparison is unsigned by default (see Optional Feature).
- Pipeline:
  - Stage 1 registers a, b, op and oe.
  - Stage 2 registers y and all flags.
  - Latency: accept (in_valid and in_ready) at edge N gives out_valid=1 after edge N+1. Throughput is one beat per cycle.
- Handshake:
  - adv2 = !s2_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - in_ready = adv1 (combinational from registered state and out_ready).
  - out_valid = s2_valid.
  - A stalled stage holds its contents unchanged. No beat is dropped or duplicated, and order is preserved.
  - With out_ready=0 the pipe holds at most 2 beats, then in_ready=0.
- Output stability: y and flags are stable while out_valid=1 and out_ready=0.
- ovf_sticky:
  - Set on the edge where out_valid & out_ready & overflow.
  - Cleared by clr_sticky.
  - If set and clear occur on the same edge, set wins.
  - Holds otherwise.
- in_valid=0: the stage-1 bubble propagates. Output registers keep their last data; out_valid falls.
- rst_n asserted mid-stream: in-flight beats are discarded, all valids go to 0, and no partial result appears after release.

Optional Feature:
- Macro ALU_PIPE_SIGNED_CMP_EN.
- Defined: greater/is_eq/less treat a and b as two's complement signed.
- Undefined: comparisons are unsigned.
- No port or latency change either way.

Test Plan:
- ADD a=0x7F b=0x01 oe=1 -> 2 cycles later y=0x80, overflow=1, parity=1, greater=1; ovf_sticky=1 after the out handshake.
- SUB a=0x05 b=0x05 -> y=0x00, is_eq=1, parity=0, overflow=0. Then clr_sticky pulse -> ovf_sticky=0. Then clr_sticky asserted together with the delivery of an overflowing beat -> ovf_sticky=1.
- SHL a=0x81 b=0x09 -> y=0x02. SHR a=0x81 b=0x07 -> y=0x01. XOR with oe=0, a=0xF0 b=0x0F -> y=0x00, parity=0.
- Compare a=0x80 b=0x01 (PASS) -> greater=1 without the macro; less=1 with ALU_PIPE_SIGNED_CMP_EN.
- Hold out_ready=0 and drive 3 back-to-back beats -> in_ready=0 after 2 are accepted; outputs stay stable. Raise out_ready -> 3 results delivered in order, one per cycle, none lost.
- Assert rst_n=0 with 2 beats in flight -> out_valid=0 and ovf_sticky=0 immediately; no stale beat after release.
